// File: rtl/instruction_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;

    // Redirect target: base + (sign-extended word offset << 2), wrapping at 32 bits.
    // The low two bits are cleared so the PC stays word aligned even if the base is not.
    function automatic logic [WORD_W-1:0] branch_target(
        input logic [WORD_W-1:0] base,
        input logic [15:0]       offset
    );
        logic [WORD_W-1:0] target;
        target = base + {{(WORD_W-18){offset[15]}}, offset, 2'b00};
        return {target[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// 256 x 32 instruction store: asynchronous read, synchronous write.
// Contents power up as NOP and are never touched by reset.
module instruction_memory
    import instruction_fetch_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   wr_en_i,
    input  logic [IMEM_ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0]      wr_data_i,
    input  logic [IMEM_ADDR_W-1:0] rd_addr_i,
    output logic [WORD_W-1:0]      rd_data_o
);

    logic [WORD_W-1:0] mem_q [IMEM_DEPTH] = '{default: NOP_INSTR};

    // Write port: a same-edge read of the written index still sees the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read port.
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Redirect (PCSrc) beats Stall, which beats a normal sequential fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              PCSrc,
    input  logic [WORD_W-1:0] BranchBasePC,
    input  logic [15:0]       BranchOffset,
    input  logic              LoadEn,
    input  logic [7:0]        LoadAddr,
    input  logic [WORD_W-1:0] LoadData,
    output logic [WORD_W-1:0] Instruction,
    output logic [WORD_W-1:0] PCPlus4,
    output logic              Valid,
    output logic [WORD_W-1:0] PC
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] fetch_word;
    logic [WORD_W-1:0] pc_inc;

    instruction_memory u_imem (
        .clk_i     (Clk),
        .wr_en_i   (LoadEn),
        .wr_addr_i (LoadAddr),
        .wr_data_i (LoadData),
        .rd_addr_i (pc_q[IMEM_ADDR_W+1:2]),
        .rd_data_o (fetch_word)
    );

    // Next PC and IF/ID contents; hold is the default so Stall needs no branch.
    always_comb begin
        pc_inc    = pc_q + 32'd4;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (PCSrc) begin
            pc_d      = branch_target(BranchBasePC, BranchOffset);
            instr_d   = NOP_INSTR;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!Stall) begin
            pc_d      = pc_inc;
            instr_d   = fetch_word;
            pcplus4_d = pc_inc;
            valid_d   = 1'b1;
        end
    end

    // PC and IF/ID registers; reset drops any pending stall or redirect.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    // Drive ports from the registers.
    always_comb begin
        PC          = pc_q;
        Instruction = instr_q;
        PCPlus4     = pcplus4_q;
        Valid       = valid_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchBasePC;
    logic [15:0] BranchOffset;
    logic        LoadEn;
    logic [7:0]  LoadAddr;
    logic [31:0] LoadData;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        Valid;
    logic [31:0] PC;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0003;
    localparam logic [31:0] W2 = 32'h0109_5020;
    localparam logic [31:0] W3 = 32'hAC0A_0000;
    localparam logic [31:0] W10 = 32'hCAFE_0001;
    localparam logic [31:0] W255 = 32'hDEAD_BEEF;
    localparam logic [31:0] W2NEW = 32'h0BAD_F00D;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] base;
        logic [15:0] off;
        logic        ld;
        logic [7:0]  la;
        logic [31:0] ldata;
    } stim_t;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] pc;
    } exp_t;

    stim_t stim_q[$];
    exp_t  sb[$];

    instruction_fetch dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .BranchBasePC (BranchBasePC),
        .BranchOffset (BranchOffset),
        .LoadEn       (LoadEn),
        .LoadAddr     (LoadAddr),
        .LoadData     (LoadData),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
        .Valid        (Valid),
        .PC           (PC)
    );

    always #5 Clk = ~Clk;

    function automatic stim_t S(input logic stall, input logic pcsrc, input logic [31:0] base,
                                input logic [15:0] off, input logic ld, input logic [7:0] la,
                                input logic [31:0] ldata);
        stim_t s;
        s.stall = stall; s.pcsrc = pcsrc; s.base = base; s.off = off;
        s.ld = ld; s.la = la; s.ldata = ldata;
        return s;
    endfunction

    function automatic exp_t E(input string tag, input logic [31:0] instr, input logic [31:0] pcp4,
                               input logic valid, input logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.instr = instr; e.pcp4 = pcp4; e.valid = valid; e.pc = pc;
        return e;
    endfunction

    // Queue one cycle of stimulus together with the state expected after its edge.
    task automatic add(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        Stall = s.stall; PCSrc = s.pcsrc; BranchBasePC = s.base; BranchOffset = s.off;
        LoadEn = s.ld; LoadAddr = s.la; LoadData = s.ldata;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    stim_t IDLE;

    task automatic test_reset();
        logic [7:0]  la [6];
        logic [31:0] ld [6];
        la = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd10, 8'd255};
        ld = '{W0, W1, W2, W3, W10, W255};
        Rst = 1'b1;
        apply(IDLE);
        #3;
        checks++;
        if ({Instruction, PCPlus4, Valid, PC} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_initial: got instr=%h pcp4=%h valid=%b pc=%h, want all zero",
                     Instruction, PCPlus4, Valid, PC);
        end
        // Loads are accepted while reset is held.
        for (int i = 0; i < 6; i++) begin
            apply(S(1'b0, 1'b1, 32'h40, 16'h1, 1'b1, la[i], ld[i]));
            tick();
        end
        apply(IDLE);
        checks++;
        if ({Instruction, PCPlus4, Valid, PC} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_held: got instr=%h pcp4=%h valid=%b pc=%h, want all zero",
                     Instruction, PCPlus4, Valid, PC);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        Rst = 1'b0;
        add(IDLE, E("seq0", W0, 32'd4, 1'b1, 32'd4));
        add(IDLE, E("seq1", W1, 32'd8, 1'b1, 32'd8));
        add(IDLE, E("seq2", W2, 32'd12, 1'b1, 32'd12));
        add(IDLE, E("seq3", W3, 32'd16, 1'b1, 32'd16));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    task automatic test_stall();
        exp_t  e;
        stim_t st;
        st = S(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 8'h0, 32'h0);
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        add(IDLE, E("stall_pre0", W0, 32'd4, 1'b1, 32'd4));
        add(IDLE, E("stall_pre1", W1, 32'd8, 1'b1, 32'd8));
        add(st,   E("stall_hold1", W1, 32'd8, 1'b1, 32'd8));
        add(st,   E("stall_hold2", W1, 32'd8, 1'b1, 32'd8));
        add(st,   E("stall_hold3", W1, 32'd8, 1'b1, 32'd8));
        add(IDLE, E("stall_resume", W2, 32'd12, 1'b1, 32'd12));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        add(S(1'b0, 1'b1, 32'h10, 16'hFFFD, 1'b0, 8'h0, 32'h0), E("branch_flush", 32'h0, 32'h0, 1'b0, 32'h4));
        add(IDLE, E("branch_target", W1, 32'd8, 1'b1, 32'd8));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t  e;
        stim_t to8;
        to8 = S(1'b0, 1'b1, 32'h0, 16'h2, 1'b0, 8'h0, 32'h0);
        add(S(1'b1, 1'b1, 32'h20, 16'h2, 1'b0, 8'h0, 32'h0), E("stall_pcsrc_flush", 32'h0, 32'h0, 1'b0, 32'h28));
        add(IDLE, E("stall_pcsrc_target", W10, 32'h2C, 1'b1, 32'h2C));
        add(to8,  E("load_pre_flush", 32'h0, 32'h0, 1'b0, 32'h8));
        add(S(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 8'd2, W2NEW), E("load_same_cycle_old", W2, 32'd12, 1'b1, 32'd12));
        add(to8,  E("load_refetch_flush", 32'h0, 32'h0, 1'b0, 32'h8));
        add(IDLE, E("load_refetch_new", W2NEW, 32'd12, 1'b1, 32'd12));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    task automatic test_wrap_uninit();
        exp_t e;
        add(S(1'b0, 1'b1, 32'h0, 16'hFFFF, 1'b0, 8'h0, 32'h0), E("wrap_flush", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC));
        add(IDLE, E("wrap_mem255", W255, 32'h0, 1'b1, 32'h0));
        add(IDLE, E("wrap_mem0", W0, 32'd4, 1'b1, 32'd4));
        add(S(1'b0, 1'b1, 32'hFFFF_FFF0, 16'h4, 1'b0, 8'h0, 32'h0), E("target_wrap", 32'h0, 32'h0, 1'b0, 32'h0));
        add(S(1'b0, 1'b1, 32'h0, 16'd50, 1'b0, 8'h0, 32'h0), E("uninit_flush", 32'h0, 32'h0, 1'b0, 32'd200));
        add(IDLE, E("uninit_nop", 32'h0, 32'd204, 1'b1, 32'd204));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        // Pending redirect plus stall, then reset lands between edges.
        apply(S(1'b1, 1'b1, 32'h100, 16'h0, 1'b0, 8'h0, 32'h0));
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if ({Instruction, PCPlus4, Valid, PC} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL async_reset_immediate: got instr=%h pcp4=%h valid=%b pc=%h, want all zero",
                     Instruction, PCPlus4, Valid, PC);
        end
        tick();
        checks++;
        if ({Instruction, PCPlus4, Valid, PC} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL async_reset_discard: got instr=%h pcp4=%h valid=%b pc=%h, want all zero",
                     Instruction, PCPlus4, Valid, PC);
        end
        Rst = 1'b0;
        add(IDLE, E("post_reset0", W0, 32'd4, 1'b1, 32'd4));
        add(IDLE, E("post_reset1", W1, 32'd8, 1'b1, 32'd8));
        add(IDLE, E("post_reset2", W2NEW, 32'd12, 1'b1, 32'd12));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = sb.pop_front();
            checks++;
            if ({Instruction, PCPlus4, Valid, PC} !== {e.instr, e.pcp4, e.valid, e.pc}) begin
                failures++;
                $display("FAIL %s: got instr=%h pcp4=%h valid=%b pc=%h, want instr=%h pcp4=%h valid=%b pc=%h",
                         e.tag, Instruction, PCPlus4, Valid, PC, e.instr, e.pcp4, e.valid, e.pc);
            end
        end
    endtask

    initial begin
        IDLE = S(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 8'h0, 32'h0);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_simultaneous();
        test_wrap_uninit();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
